// File: rtl/access_address_sync.sv
// BLE access-address synchroniser: locks symbol timing on a preamble strobe, correlates the
// access address, then streams the following PDU/CRC bits one strobe per bit.
module access_address_sync #(
   parameter int unsigned SAMPLE_RATE     = 16,
   parameter int unsigned AA_LEN          = 32,
   parameter int unsigned MAX_AA_ERRORS   = 0,
   parameter int unsigned MAX_STREAM_BITS = 2080
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              en,
   input  logic              data_bit,
   input  logic              preamble_detected,
   input  logic [AA_LEN-1:0] access_address,
   input  logic              abort,
   output logic              bit_out,
   output logic              bit_valid,
   output logic              aa_matched,
   output logic              aa_failed,
   output logic              packet_done,
   output logic              busy
);

   localparam int unsigned PH_W    = $clog2(SAMPLE_RATE);
   localparam int unsigned CNT_MAX = (MAX_STREAM_BITS > AA_LEN) ? MAX_STREAM_BITS : AA_LEN;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned ERR_W   = $clog2(AA_LEN + 1);

   // phase_cnt is cleared on the detect cycle, so enabled-cycle index k sees phase (k-1) mod SR
   localparam logic [PH_W-1:0]  PH_SAMPLE   = PH_W'(SAMPLE_RATE / 2 - 1);
   localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(SAMPLE_RATE - 1);
   localparam logic [CNT_W-1:0] AA_LAST     = CNT_W'(AA_LEN - 1);
   localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(MAX_STREAM_BITS - 1);
   localparam logic [ERR_W-1:0] ERR_LIMIT   = ERR_W'(MAX_AA_ERRORS);

   typedef enum logic [1:0] {IDLE, AA_SHIFT, STREAM} state_t;

   state_t            r_state, w_state_d;
   logic [PH_W-1:0]   r_phase_cnt, w_phase_cnt_d;
   logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_d;
   logic [AA_LEN-1:0] r_aa_sr, w_aa_sr_d;
   logic              r_bit_out, w_bit_out_d;
   logic              r_bit_valid, w_bit_valid_d;
   logic              r_aa_matched, w_aa_matched_d;
   logic              r_aa_failed, w_aa_failed_d;
   logic              r_packet_done, w_packet_done_d;

   logic              w_sample;
   logic [PH_W-1:0]   w_phase_inc;
   logic [AA_LEN-1:0] w_aa_shifted;
   logic [ERR_W-1:0]  w_err_cnt;

   always_comb begin
      w_sample     = en && (r_phase_cnt == PH_SAMPLE);
      w_phase_inc  = (r_phase_cnt == PH_LAST) ? '0 : r_phase_cnt + PH_W'(1);
      w_aa_shifted = {data_bit, r_aa_sr[AA_LEN-1:1]};
   end

   always_comb begin
      w_err_cnt = '0;
      for (int i = 0; i < AA_LEN; i++) begin
         w_err_cnt = w_err_cnt + ERR_W'(w_aa_shifted[i] ^ access_address[i]);
      end
   end

   always_comb begin
      w_state_d       = r_state;
      w_phase_cnt_d   = r_phase_cnt;
      w_bit_cnt_d     = r_bit_cnt;
      w_aa_sr_d       = r_aa_sr;
      w_bit_out_d     = r_bit_out;
      w_bit_valid_d   = 1'b0;
      w_aa_matched_d  = 1'b0;
      w_aa_failed_d   = 1'b0;
      w_packet_done_d = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (en && preamble_detected) begin
               w_state_d     = AA_SHIFT;
               w_phase_cnt_d = '0;
               w_bit_cnt_d   = '0;
            end
         end

         AA_SHIFT: begin
            if (abort) begin
               w_state_d     = IDLE;
               w_phase_cnt_d = '0;
               w_bit_cnt_d   = '0;
            end else if (en) begin
               w_phase_cnt_d = w_phase_inc;
               if (w_sample) begin
                  w_aa_sr_d = w_aa_shifted;
                  if (r_bit_cnt == AA_LAST) begin
                     w_bit_cnt_d = '0;
                     if (w_err_cnt <= ERR_LIMIT) begin
                        w_aa_matched_d = 1'b1;
                        w_state_d      = STREAM;
                     end else begin
                        w_aa_failed_d = 1'b1;
                        w_state_d     = IDLE;
                        w_phase_cnt_d = '0;
                     end
                  end else begin
                     w_bit_cnt_d = r_bit_cnt + CNT_W'(1);
                  end
               end
            end
         end

         STREAM: begin
            if (abort) begin
               w_state_d     = IDLE;
               w_phase_cnt_d = '0;
               w_bit_cnt_d   = '0;
            end else if (en) begin
               w_phase_cnt_d = w_phase_inc;
               if (w_sample) begin
                  w_bit_out_d   = data_bit;
                  w_bit_valid_d = 1'b1;
                  if (r_bit_cnt == STREAM_LAST) begin
                     w_packet_done_d = 1'b1;
                     w_state_d       = IDLE;
                     w_phase_cnt_d   = '0;
                     w_bit_cnt_d     = '0;
                  end else begin
                     w_bit_cnt_d = r_bit_cnt + CNT_W'(1);
                  end
               end
            end
         end

         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= IDLE;
         r_phase_cnt   <= '0;
         r_bit_cnt     <= '0;
         r_aa_sr       <= '0;
         r_bit_out     <= 1'b0;
         r_bit_valid   <= 1'b0;
         r_aa_matched  <= 1'b0;
         r_aa_failed   <= 1'b0;
         r_packet_done <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_phase_cnt   <= w_phase_cnt_d;
         r_bit_cnt     <= w_bit_cnt_d;
         r_aa_sr       <= w_aa_sr_d;
         r_bit_out     <= w_bit_out_d;
         r_bit_valid   <= w_bit_valid_d;
         r_aa_matched  <= w_aa_matched_d;
         r_aa_failed   <= w_aa_failed_d;
         r_packet_done <= w_packet_done_d;
      end
   end

   assign bit_out     = r_bit_out;
   assign bit_valid   = r_bit_valid;
   assign aa_matched  = r_aa_matched;
   assign aa_failed   = r_aa_failed;
   assign packet_done = r_packet_done;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_access_address_sync.sv
// Scoreboard bench for access_address_sync: the driver predicts strobe events from the
// symbol timing rules and pushes them; a negedge monitor pops and compares them.
module tb_access_address_sync;

   localparam int          SR     = 16;
   localparam int          MAXE   = 1;
   localparam int          NSTR   = 8;
   localparam logic [31:0] AA_DEF = 32'h8E89BED6;

   logic        clk = 1'b0;
   logic        resetn;
   logic        en;
   logic        data_bit;
   logic        preamble_detected;
   logic [31:0] access_address;
   logic        abort;
   logic        bit_out, bit_valid, aa_matched, aa_failed, packet_done, busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // flags = {aa_matched, aa_failed, bit_valid, packet_done}
   typedef struct {
      int         tag;
      logic [3:0] flags;
      logic       b;
   } ev_t;

   ev_t        q[$];
   ev_t        mon_e;
   logic [3:0] mon_fl;

   access_address_sync #(
      .SAMPLE_RATE    (SR),
      .AA_LEN         (32),
      .MAX_AA_ERRORS  (MAXE),
      .MAX_STREAM_BITS(NSTR)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .en               (en),
      .data_bit         (data_bit),
      .preamble_detected(preamble_detected),
      .access_address   (access_address),
      .abort            (abort),
      .bit_out          (bit_out),
      .bit_valid        (bit_valid),
      .aa_matched       (aa_matched),
      .aa_failed        (aa_failed),
      .packet_done      (packet_done),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int tag, input logic [3:0] fl, input logic b);
      ev_t e;
      e.tag   = tag;
      e.flags = fl;
      e.b     = b;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      mon_fl = {aa_matched, aa_failed, bit_valid, packet_done};
      if (mon_fl != 4'b0000) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: got flags %b at cycle %0d, expected none",
                     mon_fl, cyc);
         end else begin
            mon_e = q.pop_front();
            if (mon_e.tag != cyc || mon_e.flags != mon_fl ||
                (bit_valid && bit_out !== mon_e.b)) begin
               errors++;
               $display("FAIL event: got flags %b bit %b at cycle %0d, expected flags %b bit %b at cycle %0d",
                        mon_fl, bit_out, cyc, mon_e.flags, mon_e.b, mon_e.tag);
            end
         end
      end else if (q.size() != 0 && q[0].tag <= cyc) begin
         checks++;
         errors++;
         mon_e = q.pop_front();
         $display("FAIL missed_event: got no strobe at cycle %0d, expected flags %b", cyc,
                  mon_e.flags);
      end
   end

   // Reset in the middle of a cycle; outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      q.delete();
      #2;
      resetn            = 1'b0;
      preamble_detected = 1'b1;
      en                = 1'b1;
      #1;
      check1("rst_bit_out", bit_out, 1'b0);
      check1("rst_bit_valid", bit_valid, 1'b0);
      check1("rst_aa_matched", aa_matched, 1'b0);
      check1("rst_aa_failed", aa_failed, 1'b0);
      check1("rst_packet_done", packet_done, 1'b0);
      check1("rst_busy", busy, 1'b0);
      @(posedge clk); #1;
      check1("rst_busy_held", busy, 1'b0);
      resetn            = 1'b1;
      preamble_detected = 1'b0;
      en                = 1'b0;
   endtask

   // action: 0 = run to completion, 1 = abort after 3rd streamed bit, 2 = reset after 2nd bit
   task automatic run_packet(input logic [31:0] aa_prog, input logic [31:0] errmask,
                             input logic [7:0] payload, input int en_mode, input int action);
      logic [31:0] aa_sent;
      bit          match;
      int          last_n, k, n;
      bit          done;
      logic        e_bit, last_en, bv;
      aa_sent = aa_prog ^ errmask;
      match   = ($countones(errmask) <= MAXE);
      last_n  = match ? 32 + NSTR - 1 : 31;

      repeat ($urandom_range(2, 6)) begin
         @(posedge clk); #1;
         en                = 1'($urandom);
         data_bit          = 1'($urandom);
         preamble_detected = 1'b0;
         abort             = 1'($urandom);
         access_address    = $urandom;
      end

      @(posedge clk); #1;
      en                = 1'b1;
      preamble_detected = 1'b1;
      abort             = 1'b0;
      data_bit          = 1'($urandom);
      access_address    = aa_prog;
      k       = 0;
      done    = 1'b0;
      last_en = 1'b1;

      while (!done) begin
         @(posedge clk); #1;
         check1("busy_active", busy, 1'b1);
         preamble_detected = 1'($urandom);
         abort             = 1'b0;
         if (action == 1 && k >= SR / 2 + 34 * SR + 3) begin
            en       = 1'b0;
            abort    = 1'b1;
            data_bit = 1'($urandom);
            done     = 1'b1;
         end else if (action == 2 && k >= SR / 2 + 33 * SR + 3) begin
            do_reset();
            done = 1'b1;
         end else begin
            case (en_mode)
               0:       e_bit = 1'b1;
               1:       e_bit = ~last_en;
               default: e_bit = 1'($urandom);
            endcase
            last_en  = e_bit;
            en       = e_bit;
            data_bit = 1'($urandom);
            if (e_bit) begin
               k++;
               if (k >= SR / 2 && (k - SR / 2) % SR == 0) begin
                  n        = (k - SR / 2) / SR;
                  bv       = (n < 32) ? aa_sent[n] : payload[n-32];
                  data_bit = bv;
                  if (n == 31)
                     push_ev(cyc + 1, match ? 4'b1000 : 4'b0100, 1'b0);
                  else if (n > 31)
                     push_ev(cyc + 1, {3'b001, (n == last_n)}, bv);
                  if (n == last_n) done = 1'b1;
               end
            end
         end
      end

      if (action != 2) begin
         @(posedge clk); #1;
         check1("busy_cleared", busy, 1'b0);
         preamble_detected = 1'b0;
         abort             = 1'b0;
         en                = 1'($urandom);
         data_bit          = 1'($urandom);
      end
   endtask

   initial begin
      logic [31:0] mask;
      int          w;
      resetn            = 1'b0;
      en                = 1'b0;
      data_bit          = 1'b0;
      preamble_detected = 1'b0;
      abort             = 1'b0;
      access_address    = '0;
      repeat (2) @(posedge clk);
      #1;
      check1("init_bit_out", bit_out, 1'b0);
      check1("init_bit_valid", bit_valid, 1'b0);
      check1("init_aa_matched", aa_matched, 1'b0);
      check1("init_aa_failed", aa_failed, 1'b0);
      check1("init_packet_done", packet_done, 1'b0);
      check1("init_busy", busy, 1'b0);
      resetn = 1'b1;

      run_packet(AA_DEF, 32'h0, 8'hA5, 0, 0);
      run_packet(AA_DEF, 32'h0000_0020, 8'h3C, 0, 0);
      run_packet(AA_DEF, 32'h0002_0020, 8'hFF, 0, 0);
      run_packet(AA_DEF, 32'h0, 8'($urandom), 1, 0);
      run_packet(AA_DEF, 32'h0, 8'hA5, 2, 1);
      run_packet($urandom, 32'h0, 8'($urandom), 2, 0);
      run_packet(AA_DEF, 32'h0, 8'h5A, 0, 2);
      run_packet(AA_DEF, 32'h0, 8'hC3, 1, 0);
      for (int i = 0; i < 6; i++) begin
         mask = '0;
         repeat ($urandom_range(0, 3)) mask[$urandom_range(0, 31)] = 1'b1;
         run_packet($urandom, mask, 8'($urandom), int'($urandom_range(0, 2)), 0);
      end

      w = 0;
      while (q.size() != 0 && w < 50) begin
         @(posedge clk);
         w++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending events expected 0", q.size());
      end
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/access_address_sync.md
Name: access_address_sync

Overview:
- Stage directly downstream of preamble_detect in the BLE receiver; consumes the same oversampled matched-filter bit stream plus the preamble_detected strobe.
- On a preamble hit it locks bit timing to the detected transition and samples one bit per symbol at mid-symbol.
- It then correlates the first 32 symbols against the programmed access address.
- On a match it streams the following PDU/CRC bits, one strobe per bit, to the dewhitening/packet stage. On a mismatch it rearms.

Parameters:
- SAMPLE_RATE, 16: samples per symbol; must be even and >= 4.
- AA_LEN, 32: access address length in bits.
- MAX_AA_ERRORS, 0: maximum number of mismatching AA bits still accepted as a match.
- MAX_STREAM_BITS, 2080: maximum number of bits streamed after the AA (257-byte PDU plus 24-bit CRC).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- en  in  1  sample enable; all state advances only when en=1
- data_bit  in  1  matched-filter output, one sample per enabled cycle
- preamble_detected  in  1  preamble_detect strobe, valid in enabled cycles
- access_address  in  32  expected AA; bit 0 is the first bit on air; sampled when the AA comparison is made
- abort  in  1  downstream request to stop streaming and return to idle
- bit_out  out  1  sampled symbol value, valid while bit_valid=1
- bit_valid  out  1  one-clk strobe per streamed bit
- aa_matched  out  1  one-clk pulse when the AA is accepted
- aa_failed  out  1  one-clk pulse when the AA is rejected
- packet_done  out  1  one-clk pulse coinciding with the last streamed bit
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; all counters and the shift register are cleared; every output is 0.
- All outputs are registered. Strobe outputs are one clk wide; they are deasserted on the next clk edge even if en=0.
- States are IDLE, AA_SHIFT and STREAM.

IDLE:
- On en=1 and preamble_detected=1: go to AA_SHIFT; clear phase_cnt and bit_cnt.
- The detect cycle is enabled-cycle index 0.

Symbol sampling (AA_SHIFT and STREAM):
- phase_cnt counts enabled cycles only.
- A sample is taken at enabled-cycle indices SAMPLE_RATE/2 + n*SAMPLE_RATE after detect, for n = 0, 1, 2, … (default: 8, 24, 40, …).
- The sample value is data_bit in that cycle.
- With en=0 nothing advances and no output changes, except that strobes clear.

AA_SHIFT:
- Each sample shifts into aa_sr at the MSB, shifting right, so that after 32 samples aa_sr[0] holds the first bit received.
- On the 32nd sample, compare the new shift value with access_address and count the differing bits (popcount of the XOR).
- If the count is <= MAX_AA_ERRORS: pulse aa_matched, go to STREAM, bit_cnt=0.
- Otherwise: pulse aa_failed, go to IDLE.
- Both pulses are asserted from the edge at which the 32nd sample is captured.
- With default parameters that is the edge closing enabled-cycle 8 + 31*16 = 504.

STREAM:
- Each sample drives bit_out and pulses bit_valid in the same edge; bit_cnt increments.
- On sample number MAX_STREAM_BITS: also pulse packet_done and go to IDLE.

abort:
- Checked independent of en. It has priority over sampling in the same cycle.
- The next edge returns to IDLE, emits no bit_valid and no packet_done, and clears the counters.
- Ignored in IDLE.

Other rules:
- preamble_detected is ignored outside IDLE; there is no restart mid-packet.
- A preamble in the same cycle that IDLE is re-entered is not captured; detection needs a following enabled cycle.
- Counter widths: phase_cnt is $clog2(SAMPLE_RATE) bits and wraps naturally; bit_cnt is $clog2(MAX_STREAM_BITS+1) bits and never wraps, because it is bounded by the terminal compare.

Test Plan:
- AA match: preamble strobe, then AA 0x8E89BED6 sent LSB first at 16 samples/bit with access_address=0x8E89BED6 -> aa_matched pulse exactly 504 enabled cycles after detect; busy=1 throughout; aa_failed=0.
- AA mismatch: same as the match case but bit 5 flipped, MAX_AA_ERRORS=0 -> aa_failed pulse at cycle 504; state back to IDLE; busy=0 next clk. With MAX_AA_ERRORS=1 -> aa_matched instead.
- Stream: after a match, send pattern 0xA5 LSB first, with MAX_STREAM_BITS=8 -> bit_valid strobes at enabled cycles 520, 536, …, 632; bit_out sequence 1,0,1,0,0,1,0,1; packet_done coincides with the 8th strobe; busy=0 after it.
- en gaps: en toggling 1/0 every clk -> sample instants stretch to the enabled-cycle indices above; no output changes while en=0; strobes last 1 clk.
- abort after the 3rd streamed bit, asserted in a cycle with en=0 -> IDLE at the next edge; no further bit_valid; no packet_done. A new preamble is then accepted.
- Reset mid-STREAM (resetn low for 1 clk) -> all outputs 0 immediately (asynchronously); busy=0; a preamble asserted while in AA_SHIFT and also after reset -> only the post-reset one starts a new sync.
